// File: rtl/xnorconv_sequencer_if.sv
// Bus between xnorconv_sequencer and its environment: batch control,
// scratchpad strobes and addresses, and the accelerator result.
interface xnorconv_sequencer_if #(
    parameter int NUMHELPER       = 4,
    parameter int INPUT_BITWIDTH  = 25,
    parameter int OUTPUT_BITWIDTH = 6,
    parameter int SIZE            = 16
);
    localparam int AW = $clog2(SIZE);

    logic                                 start;
    logic [AW-1:0]                        in_base;
    logic [AW-1:0]                        wt_base;
    logic [AW-1:0]                        out_base;
    logic [AW:0]                          count;
    logic                                 busy;
    logic                                 done;
    logic                                 in_on;
    logic                                 wt_on;
    logic [AW-1:0]                        in_addr;
    logic [AW-1:0]                        wt_addr;
    logic                                 acc_reset;
    logic [NUMHELPER*OUTPUT_BITWIDTH-1:0] pe_out_c;
    logic                                 out_on;
    logic                                 out_we;
    logic [AW-1:0]                        out_addr;
    logic [NUMHELPER*INPUT_BITWIDTH-1:0]  out_data;

    modport master (
        input  start, in_base, wt_base, out_base, count, pe_out_c,
        output busy, done, in_on, wt_on, in_addr, wt_addr, acc_reset,
               out_on, out_we, out_addr, out_data
    );

    modport slave (
        output start, in_base, wt_base, out_base, count, pe_out_c,
        input  busy, done, in_on, wt_on, in_addr, wt_addr, acc_reset,
               out_on, out_we, out_addr, out_data
    );
endinterface

// File: rtl/xnorconv_sequencer.sv
// Batch sequencer for the XNOR-convolution accelerator: issues scratchpad reads,
// writes results back. Define XNORSEQ_ACCUM_EN to sum all vectors into one write.
module xnorconv_sequencer #(
    parameter int NUMHELPER       = 4,
    parameter int INPUT_BITWIDTH  = 25,
    parameter int OUTPUT_BITWIDTH = 6,
    parameter int SIZE            = 16
) (
    input logic                  clock,
    input logic                  reset,
    xnorconv_sequencer_if.master bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam int IW = INPUT_BITWIDTH;
    localparam int OW = OUTPUT_BITWIDTH;
`ifdef XNORSEQ_ACCUM_EN
    localparam int DRAIN_LEN = 3;  // extra cycle to turn the final sum into a write
`else
    localparam int DRAIN_LEN = 2;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] issued_q;
    logic [1:0]    drain_q;
    logic          p1_valid;
    logic          launch;
    logic          issue;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == AW'(SIZE - 1)) ? '0 : a + AW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned before the case so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.count == '0) ? DONE : RUN;
            RUN:     if (issued_q == cnt_q) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'(DRAIN_LEN - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign launch = (state_q == IDLE) && bus.start;
    assign issue  = (state_d == RUN);

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: every register uses <= so all flops see pre-edge values regardless of order.
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.acc_reset <= 1'b1;
            bus.in_on     <= 1'b0;
            bus.wt_on     <= 1'b0;
            bus.in_addr   <= '0;
            bus.wt_addr   <= '0;
            cnt_q         <= '0;
            issued_q      <= '0;
            drain_q       <= '0;
            p1_valid      <= 1'b0;
        end else begin
            bus.busy      <= (state_d != IDLE);
            bus.done      <= (state_d == DONE);
            bus.acc_reset <= (state_d == IDLE) || (state_d == DONE);
            bus.in_on     <= issue;
            bus.wt_on     <= issue;
            p1_valid      <= bus.in_on;
            drain_q       <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
            if (launch) cnt_q <= bus.count;
            if (launch && issue) begin
                bus.in_addr <= bus.in_base;
                bus.wt_addr <= bus.wt_base;
                issued_q    <= CW'(1);
            end else if (issue) begin
                bus.in_addr <= wrap_inc(bus.in_addr);
                bus.wt_addr <= wrap_inc(bus.wt_addr);
                issued_q    <= issued_q + CW'(1);
            end
        end
    end

`ifndef XNORSEQ_ACCUM_EN
    logic [AW-1:0] iss_oaddr;
    logic [AW-1:0] p1_addr;

    function automatic logic [NUMHELPER*IW-1:0] widen(input logic [NUMHELPER*OW-1:0] pe);
        logic [NUMHELPER*IW-1:0] w;
        for (int j = 0; j < NUMHELPER; j++) w[j*IW +: IW] = IW'($signed(pe[j*OW +: OW]));
        return w;
    endfunction

    // Stage 0 rides with the issue strobe, stage 1 with the accelerator result.
    always_ff @(posedge clock) begin
        if (reset) begin
            iss_oaddr    <= '0;
            p1_addr      <= '0;
            bus.out_on   <= 1'b0;
            bus.out_we   <= 1'b0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
        end else begin
            if (launch)         iss_oaddr <= bus.out_base;
            else if (bus.in_on) iss_oaddr <= wrap_inc(iss_oaddr);
            p1_addr    <= iss_oaddr;
            bus.out_on <= p1_valid;
            bus.out_we <= p1_valid;
            if (p1_valid) begin
                bus.out_addr <= p1_addr;
                bus.out_data <= widen(bus.pe_out_c);
            end else begin
                bus.out_data <= '0;
            end
        end
    end
`else
    localparam int AB = OW + AW;

    logic signed [AB-1:0] acc_q [NUMHELPER];
    logic [AW-1:0]        out_base_q;
    logic                 fire;

    // The last lane result lands one cycle before this, so the sum is final here.
    assign fire = (state_q == DRAIN) && (drain_q == 2'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the accumulator is a handful of flops, not a RAM, so it is reset like any register.
            for (int j = 0; j < NUMHELPER; j++) acc_q[j] <= '0;
            out_base_q   <= '0;
            bus.out_on   <= 1'b0;
            bus.out_we   <= 1'b0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
        end else begin
            if (launch) out_base_q <= bus.out_base;
            for (int j = 0; j < NUMHELPER; j++) begin
                if (launch)        acc_q[j] <= '0;
                else if (p1_valid) acc_q[j] <= acc_q[j] + AB'($signed(bus.pe_out_c[j*OW +: OW]));
            end
            bus.out_on <= fire;
            bus.out_we <= fire;
            if (fire) begin
                bus.out_addr <= out_base_q;
                for (int j = 0; j < NUMHELPER; j++) bus.out_data[j*IW +: IW] <= IW'(acc_q[j]);
            end else begin
                bus.out_data <= '0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_xnorconv_sequencer.sv
// Bench for xnorconv_sequencer: scratchpad/accelerator model, activity logs, and
// directed plus randomized batches compared against expectations built from the XNOR rule.
module tb_xnorconv_sequencer;
    localparam int NH   = 4;
    localparam int IW   = 25;
    localparam int OW   = 6;
    localparam int SIZE = 16;
    localparam int AW   = 4;
    localparam int DW   = NH * IW;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic [AW-1:0] ia;   logic [AW-1:0] wa;   } rd_t;
    typedef int iq_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [DW-1:0] in_mem [SIZE];
    logic [DW-1:0] wt_mem [SIZE];
    logic [DW-1:0] rd_in = '0;
    logic [DW-1:0] rd_wt = '0;

    wr_t wr_log[$];
    rd_t rd_log[$];
    iq_t busy_log, done_log, run_log, bad_log;

    always #5 clock = ~clock;

    xnorconv_sequencer_if #(.NUMHELPER(NH), .INPUT_BITWIDTH(IW),
                            .OUTPUT_BITWIDTH(OW), .SIZE(SIZE)) bus ();

    xnorconv_sequencer #(.NUMHELPER(NH), .INPUT_BITWIDTH(IW),
                         .OUTPUT_BITWIDTH(OW), .SIZE(SIZE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Accelerator rule: +1 per matching bit, -1 per differing bit.
    function automatic int lane_res(input logic [IW-1:0] a, input logic [IW-1:0] b);
        int m = 0;
        for (int i = 0; i < IW; i++) if (a[i] == b[i]) m++;
        return 2 * m - IW;
    endfunction

    function automatic iq_t pick(input iq_t q, input int lo, input int hi);
        iq_t r;
        foreach (q[i]) if (q[i] > lo && q[i] <= hi) r.push_back(q[i]);
        return r;
    endfunction

    // Scratchpads read with one cycle of latency; the result then feeds out combinationally.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.in_on) rd_in <= in_mem[bus.in_addr];
        if (bus.wt_on) rd_wt <= wt_mem[bus.wt_addr];
    end

    always_comb begin
        bus.pe_out_c = '0;
        if (!bus.acc_reset)
            for (int j = 0; j < NH; j++)
                bus.pe_out_c[j*OW +: OW] = OW'(lane_res(rd_in[j*IW +: IW], rd_wt[j*IW +: IW]));
    end

    always @(negedge clock) begin
        if (bus.busy)       busy_log.push_back(cyc);
        if (bus.done)       done_log.push_back(cyc);
        if (!bus.acc_reset) run_log.push_back(cyc);
        if (bus.in_on)      rd_log.push_back('{cyc, bus.in_addr, bus.wt_addr});
        if (bus.out_we)     wr_log.push_back('{cyc, bus.out_addr, bus.out_data});
        if (bus.in_on !== bus.wt_on || bus.out_on !== bus.out_we) bad_log.push_back(cyc);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < SIZE; i++) begin
            case (mode)
                0:       begin in_mem[i] = '1; wt_mem[i] = '1; end
                1:       begin in_mem[i] = '1; wt_mem[i] = '0; end
                default: begin
                    in_mem[i] = DW'({$urandom, $urandom, $urandom, $urandom});
                    wt_mem[i] = DW'({$urandom, $urandom, $urandom, $urandom});
                end
            endcase
        end
    endtask

    task automatic run_batch(input int ib, input int wb, input int ob, input int n, input bit pulse);
        int            t0, t1, exp_done, exp_run, v;
        int            sum [NH];
        logic [DW-1:0] d;
        wr_t           exp_wr[$];
        wr_t           got_wr[$];
        rd_t           got_rd[$];
        iq_t           got;

        for (int j = 0; j < NH; j++) sum[j] = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < NH; j++) begin
                v = lane_res(in_mem[(ib + k) % SIZE][j*IW +: IW], wt_mem[(wb + k) % SIZE][j*IW +: IW]);
                d[j*IW +: IW] = IW'(v);
                sum[j] += v;
            end
`ifndef XNORSEQ_ACCUM_EN
            exp_wr.push_back('{k + 3, AW'((ob + k) % SIZE), d});
`endif
        end
`ifdef XNORSEQ_ACCUM_EN
        for (int j = 0; j < NH; j++) d[j*IW +: IW] = IW'(sum[j]);
        if (n > 0) exp_wr.push_back('{n + 3, AW'(ob), d});
        exp_done = (n == 0) ? 1 : n + 4;
        exp_run  = (n == 0) ? 0 : n + 3;
`else
        exp_done = (n == 0) ? 1 : n + 3;
        exp_run  = (n == 0) ? 0 : n + 2;
`endif

        @(negedge clock);
        bus.in_base  = AW'(ib);
        bus.wt_base  = AW'(wb);
        bus.out_base = AW'(ob);
        bus.count    = 5'(n);
        bus.start    = 1'b1;
        t0 = cyc;
        for (int c = 1; c <= n + 8; c++) begin
            @(negedge clock);
            bus.start = pulse && (c == 2);
            if (pulse && c == 2) bus.count = 5'd3;
        end
        t1 = t0 + n + 8;

        got = pick(done_log, t0, t1);
        check("done_count", got.size(), 1);
        check("done_cycle", (got.size() > 0) ? got[0] - t0 : -1, exp_done);
        got = pick(busy_log, t0, t1);
        check("busy_cycles", got.size(), exp_done);
        check("busy_first", (got.size() > 0) ? got[0] - t0 : -1, 1);
        got = pick(run_log, t0, t1);
        check("acc_reset_low", got.size(), exp_run);
        got = pick(bad_log, t0, t1);
        check("strobe_pairs", got.size(), 0);

        foreach (rd_log[i]) if (rd_log[i].cyc > t0 && rd_log[i].cyc <= t1) got_rd.push_back(rd_log[i]);
        check("read_count", got_rd.size(), n);
        for (int i = 0; i < n && i < got_rd.size(); i++)
            check("read", {got_rd[i].cyc - t0, got_rd[i].ia, got_rd[i].wa},
                  {i + 1, AW'((ib + i) % SIZE), AW'((wb + i) % SIZE)});

        foreach (wr_log[i]) if (wr_log[i].cyc > t0 && wr_log[i].cyc <= t1) got_wr.push_back(wr_log[i]);
        check("write_count", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check("write", {8'(got_wr[i].cyc - t0), got_wr[i].addr, got_wr[i].data},
                  {8'(exp_wr[i].cyc), exp_wr[i].addr, exp_wr[i].data});
    endtask

    initial begin
        int  t0, n;
        iq_t got;

        bus.start    = 1'b0;
        bus.in_base  = '0;
        bus.wt_base  = '0;
        bus.out_base = '0;
        bus.count    = '0;
        fill(0);

        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_strobes", {bus.in_on, bus.wt_on, bus.out_on, bus.out_we}, 4'b0000);
        check("rst_addrs", {bus.in_addr, bus.wt_addr, bus.out_addr}, 12'h000);
        check("rst_out_data", bus.out_data, '0);
        check("rst_acc_reset", bus.acc_reset, 1'b1);

        reset = 1'b0;
        t0 = cyc;
        repeat (4) @(negedge clock);
        got = pick(busy_log, t0, cyc);
        check("idle_busy", got.size(), 0);
        check("idle_reads", rd_log.size() + wr_log.size(), 0);
        check("idle_acc_reset", bus.acc_reset, 1'b1);

        fill(0); run_batch(0, 0, 0, 16, 1'b0);
        fill(1); run_batch(0, 0, 0, 4, 1'b0);
        fill(2); run_batch(14, 2, 15, 4, 1'b0);
        run_batch(3, 5, 7, 0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            fill(2);
            run_batch($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(2, 16), 1'b1);
        end

        // Reset lands in cycle 5 of a long batch.
        fill(0);
        @(negedge clock);
        bus.in_base = '0; bus.wt_base = '0; bus.out_base = '0;
        bus.count = 5'd16; bus.start = 1'b1;
        t0 = cyc;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_acc_reset", bus.acc_reset, 1'b1);
        check("mid_rst_strobes", {bus.in_on, bus.out_we}, 2'b00);
        repeat (20) @(negedge clock);
        got = pick(done_log, t0, cyc);
        check("mid_rst_no_done", got.size(), 0);
        n = 0;
        foreach (wr_log[i]) if (wr_log[i].cyc >= t0 + 6) n++;
        check("mid_rst_no_writes", n, 0);
        run_batch(0, 0, 0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
